bounds_tracker: RTL and testbench
=================================

# bounds_tracker

Registered, flow-controlled voxel bounds checker placed between the DDA voxel stepper and the voxel-fetch stage. It checks each stepped voxel coordinate against per-axis limits, with optional signed (negative = outside) coordinates. It reports which axes exited, counts in-bounds steps per ray, and terminates a ray at its first out-of-bounds voxel by silently draining the ray's remaining steps.

## Interface
Parameters:
- COORD_W, 6, coordinate width per axis
- MAX_X / MAX_Y / MAX_Z, 31 / 31 / 31, inclusive upper limit per axis
- SIGNED_COORDS, 0, 1 = coordinates are two's complement and any negative value is out of bounds
- RAY_ID_W, 4, ray tag width
- STEP_W, 8, per-ray in-bounds step counter width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- in_valid / in_ready  in / out  1  input handshake
- in_ix, in_iy, in_iz  in  COORD_W  voxel coordinate
- in_last  in  1  final step of this ray from the stepper
- in_ray_id  in  RAY_ID_W  ray tag
- out_valid / out_ready  out / in  1  output handshake
- out_ix, out_iy, out_iz  out  COORD_W  registered copy of the accepted coordinate
- out_ray_id  out  RAY_ID_W  tag of the emitted beat
- out_oob  out  1  this voxel is outside the volume
- out_axis  out  3  exited axes, bit0 = x, bit1 = y, bit2 = z
- out_end  out  1  last beat emitted for this ray (out_oob or in_last)
- out_steps  out  STEP_W  in-bounds beats of this ray up to and including this beat

## Operation
- Per-axis out-of-bounds test, unsigned mode: coord > MAX_a, compared at full width. If MAX_a >= 2^COORD_W−1, that axis is never out of bounds.
- Per-axis test, signed mode: coord[MSB] = 1, or coord > MAX_a as unsigned. MAX_a < 2^(COORD_W−1) is required; this is checked by an elaboration-time assertion.
- out_axis = the three per-axis results. out_oob = OR of out_axis.
- Two-state FSM, RUN and DRAIN; reset state is RUN.
- RUN: accept a beat when in_valid && in_ready. Register the coordinates, ray_id, out_axis and out_oob; set out_valid = 1.
  - In-bounds beat: step_cnt += 1, saturating at all-ones. out_steps = the incremented value. out_end = in_last.
  - Out-of-bounds beat: step_cnt is not incremented. out_steps = the current count. out_end = 1. If in_last = 0, go to DRAIN.
  - After any end beat is accepted, step_cnt clears to 0.
- DRAIN: in_ready = 1 unconditionally. Accepted beats are discarded and never emitted. A beat with in_last = 1 returns the FSM to RUN with step_cnt = 0. Output-side state is unaffected, so a held out_valid beat still completes normally.
- in_ready in RUN = !out_valid || out_ready. This gives full throughput with a single output register.
- out_valid drops only on out_ready with no new accept in the same cycle. Output fields are stable while out_valid && !out_ready.

## Timing
- Latency: exactly 1 cycle from input accept to out_valid.
- Throughput: 1 beat/cycle when out_ready = 1.
- Reset values: out_valid = 0, FSM = RUN, step_cnt = 0, all data outputs = 0. in_ready = 1 during and after reset.
- Reset mid-ray: the in-flight output beat and drain state are lost. The next accepted beat starts a fresh ray.
- Simultaneous out_ready and a new accept: the register is overwritten with no bubble.
- OOB beat with in_last = 1: the FSM stays in RUN and the next cycle may accept a new ray.
- Counter saturation: at 2^STEP_W−1, further in-bounds beats hold the value. The next end beat still clears it.

## Structure
- Package bounds_pkg holds:
  - typedef axis_mask_t (logic [2:0]) and its X/Y/Z bit index constants
  - enum bt_state_e {BT_RUN, BT_DRAIN}
- Sub-module axis_limit_cmp (params COORD_W, MAX_VAL, SIGNED_COORDS): combinational single-axis test, instantiated three times.

## Test plan
- COORD_W = 6, unsigned, out_ready = 1. Ray id 3, beats (0,0,0), (31,31,31), (31,31,32, last) → three outputs at 1-cycle latency: oob 0,0,1; out_axis 000,000,100; out_steps 1,2,2; out_end only on the third.
- OOB mid-ray: beats (10,10,10), (32,5,5), (33,5,5), (34,5,5, last), then new ray (1,1,1, last) → out_axis = 001 and out_end on beat 2. Beats 3–4 are consumed with no output. The next ray outputs steps = 1, out_end = 1.
- SIGNED_COORDS = 1, COORD_W = 6: beat (−1,0,0) = 6'h3F → oob = 1, out_axis = 001. Beat (31,0,0) → oob = 0.
- Backpressure: out_ready = 0 for 5 cycles with in_valid held → in_ready = 0 and outputs hold. Then out_ready = 1 → one beat per cycle with no loss or duplication. Continue with randomized in_valid/out_ready over 10000 beats against a reference model.
- STEP_W = 2, a 6-beat in-bounds ray → out_steps 1,2,3,3,3,3. The next ray starts again at 1.
- Assert rst for 1 cycle while out_valid = 1 in DRAIN → out_valid = 0 asynchronously, and the FSM is in RUN. The next beat (5,5,5, last) is emitted with steps = 1.

Source files
------------

// File: rtl/bounds_pkg.sv
// Shared types for the voxel bounds checker: axis mask layout and FSM states.
package bounds_pkg;

    typedef logic [2:0] axis_mask_t;

    localparam int AXIS_X = 0;
    localparam int AXIS_Y = 1;
    localparam int AXIS_Z = 2;

    typedef enum logic {
        BT_RUN   = 1'b0,
        BT_DRAIN = 1'b1
    } bt_state_e;

endpackage

// File: rtl/axis_limit_cmp.sv
// Single-axis out-of-bounds test. Coordinates are widened to 32 bits before
// the compare, so a limit at or above the coordinate range never trips.
module axis_limit_cmp #(
    parameter int COORD_W       = 6,
    parameter int MAX_VAL       = 31,
    parameter int SIGNED_COORDS = 0
) (
    input  logic [COORD_W-1:0] coord,
    output logic               oob
);

    // In signed mode a limit reaching into the negative half would make
    // positive coordinates look negative, so refuse to elaborate.
    generate
        if ((SIGNED_COORDS != 0) && (MAX_VAL >= (1 << (COORD_W - 1)))) begin : g_bad_limit
            $error("axis_limit_cmp: MAX_VAL must be below 2**(COORD_W-1) in signed mode");
        end
    endgenerate

    logic above_limit;

    // Full-width magnitude compare, plus the sign bit when coordinates are signed.
    always_comb begin
        above_limit = (32'(coord) > 32'(MAX_VAL));
        oob         = above_limit;
        if (SIGNED_COORDS != 0) begin
            oob = above_limit | coord[COORD_W-1];
        end
    end

endmodule

// File: rtl/bounds_tracker.sv
// Registered voxel bounds checker between the DDA stepper and voxel fetch.
// Flags exited axes, counts in-bounds steps per ray and drains the rest of a
// ray after its first out-of-bounds voxel.
module bounds_tracker
    import bounds_pkg::*;
#(
    parameter int COORD_W       = 6,
    parameter int MAX_X         = 31,
    parameter int MAX_Y         = 31,
    parameter int MAX_Z         = 31,
    parameter int SIGNED_COORDS = 0,
    parameter int RAY_ID_W      = 4,
    parameter int STEP_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COORD_W-1:0]  in_ix,
    input  logic [COORD_W-1:0]  in_iy,
    input  logic [COORD_W-1:0]  in_iz,
    input  logic                in_last,
    input  logic [RAY_ID_W-1:0] in_ray_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COORD_W-1:0]  out_ix,
    output logic [COORD_W-1:0]  out_iy,
    output logic [COORD_W-1:0]  out_iz,
    output logic [RAY_ID_W-1:0] out_ray_id,
    output logic                out_oob,
    output logic [2:0]          out_axis,
    output logic                out_end,
    output logic [STEP_W-1:0]   out_steps
);

    axis_mask_t          axis_hit;
    logic                beat_oob;
    bt_state_e           state;
    bt_state_e           state_next;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_inc;
    logic                accept;
    logic                run_accept;

    axis_limit_cmp #(
        .COORD_W       (COORD_W),
        .MAX_VAL       (MAX_X),
        .SIGNED_COORDS (SIGNED_COORDS)
    ) u_cmp_x (
        .coord (in_ix),
        .oob   (axis_hit[AXIS_X])
    );

    axis_limit_cmp #(
        .COORD_W       (COORD_W),
        .MAX_VAL       (MAX_Y),
        .SIGNED_COORDS (SIGNED_COORDS)
    ) u_cmp_y (
        .coord (in_iy),
        .oob   (axis_hit[AXIS_Y])
    );

    axis_limit_cmp #(
        .COORD_W       (COORD_W),
        .MAX_VAL       (MAX_Z),
        .SIGNED_COORDS (SIGNED_COORDS)
    ) u_cmp_z (
        .coord (in_iz),
        .oob   (axis_hit[AXIS_Z])
    );

    // Handshake: drain swallows everything, run accepts whenever the output slot frees up.
    always_comb begin
        beat_oob   = |axis_hit;
        in_ready   = (state == BT_DRAIN) ? 1'b1 : (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        run_accept = accept && (state == BT_RUN);
        step_inc   = (&step_cnt) ? step_cnt : step_cnt + 1'b1;
    end

    // Next state: an out-of-bounds beat that is not the ray's last starts a drain.
    always_comb begin
        state_next = state;
        case (state)
            BT_RUN: begin
                if (run_accept && beat_oob && !in_last) begin
                    state_next = BT_DRAIN;
                end
            end
            BT_DRAIN: begin
                if (accept && in_last) begin
                    state_next = BT_RUN;
                end
            end
            default: state_next = BT_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BT_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Per-ray in-bounds step counter, cleared whenever a ray's end beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (run_accept) begin
            step_cnt <= (beat_oob || in_last) ? '0 : step_inc;
        end else if (accept && in_last) begin
            step_cnt <= '0;
        end
    end

    // Single output register: loaded on a run accept, emptied on a take with no refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ix     <= '0;
            out_iy     <= '0;
            out_iz     <= '0;
            out_ray_id <= '0;
            out_oob    <= 1'b0;
            out_axis   <= '0;
            out_end    <= 1'b0;
            out_steps  <= '0;
        end else if (run_accept) begin
            out_valid  <= 1'b1;
            out_ix     <= in_ix;
            out_iy     <= in_iy;
            out_iz     <= in_iz;
            out_ray_id <= in_ray_id;
            out_oob    <= beat_oob;
            out_axis   <= axis_hit;
            out_end    <= beat_oob | in_last;
            out_steps  <= beat_oob ? step_cnt : step_inc;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bounds_tracker.sv
// Scoreboard bench for bounds_tracker: dut 0 uses default parameters,
// dut 1 uses signed coordinates with a 2-bit step counter.
module tb_bounds_tracker;

    typedef struct packed {
        logic [5:0] ix;
        logic [5:0] iy;
        logic [5:0] iz;
        logic [3:0] id;
        logic       oob;
        logic [2:0] axis;
        logic       end_flag;
        logic [7:0] steps;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [5:0] in_ix     [2];
    logic [5:0] in_iy     [2];
    logic [5:0] in_iz     [2];
    logic       in_last   [2];
    logic [3:0] in_ray_id [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [5:0] out_ix    [2];
    logic [5:0] out_iy    [2];
    logic [5:0] out_iz    [2];
    logic [3:0] out_ray_id[2];
    logic       out_oob   [2];
    logic [2:0] out_axis  [2];
    logic       out_end   [2];
    logic [7:0] a_steps;
    logic [1:0] b_steps;
    logic [7:0] out_steps [2];

    beat_t      exp_q0[$];
    beat_t      exp_q1[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic       m_drain;
    logic [7:0] m_cnt;
    logic       rand_done;

    bounds_tracker u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .in_ix      (in_ix[0]),
        .in_iy      (in_iy[0]),
        .in_iz      (in_iz[0]),
        .in_last    (in_last[0]),
        .in_ray_id  (in_ray_id[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_ix     (out_ix[0]),
        .out_iy     (out_iy[0]),
        .out_iz     (out_iz[0]),
        .out_ray_id (out_ray_id[0]),
        .out_oob    (out_oob[0]),
        .out_axis   (out_axis[0]),
        .out_end    (out_end[0]),
        .out_steps  (a_steps)
    );

    bounds_tracker #(
        .SIGNED_COORDS (1),
        .STEP_W        (2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .in_ix      (in_ix[1]),
        .in_iy      (in_iy[1]),
        .in_iz      (in_iz[1]),
        .in_last    (in_last[1]),
        .in_ray_id  (in_ray_id[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_ix     (out_ix[1]),
        .out_iy     (out_iy[1]),
        .out_iz     (out_iz[1]),
        .out_ray_id (out_ray_id[1]),
        .out_oob    (out_oob[1]),
        .out_axis   (out_axis[1]),
        .out_end    (out_end[1]),
        .out_steps  (b_steps)
    );

    // Present both step counters at a common width for the monitor.
    always_comb begin
        out_steps[0] = a_steps;
        out_steps[1] = {6'd0, b_steps};
    end

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBeat(input int s);
        beat_t got;
        beat_t e;
        got.ix       = out_ix[s];
        got.iy       = out_iy[s];
        got.iz       = out_iz[s];
        got.id       = out_ray_id[s];
        got.oob      = out_oob[s];
        got.axis     = out_axis[s];
        got.end_flag = out_end[s];
        got.steps    = out_steps[s];
        tests_run++;
        if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_output dut%0d: got ix=%0d iy=%0d iz=%0d id=%0d, expected no beat",
                     s, got.ix, got.iy, got.iz, got.id);
        end else begin
            e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got !== e) begin
                tests_failed++;
                $display("[TB] FAIL beat dut%0d: got (%0d,%0d,%0d) id=%0d oob=%0b axis=%03b end=%0b steps=%0d expected (%0d,%0d,%0d) id=%0d oob=%0b axis=%03b end=%0b steps=%0d",
                         s, got.ix, got.iy, got.iz, got.id, got.oob, got.axis, got.end_flag, got.steps,
                         e.ix, e.iy, e.iz, e.id, e.oob, e.axis, e.end_flag, e.steps);
            end
        end
    endtask

    // Monitor: a beat transfers at the next rising edge when valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int s = 0; s < 2; s++) begin
                    if (out_valid[s] && out_ready[s]) begin
                        checkBeat(s);
                    end
                end
            end
        end
    end

    task automatic modelStep(input logic [5:0] ix, input logic [5:0] iy, input logic [5:0] iz,
                             input logic last, input logic [3:0] id,
                             output logic emit, output beat_t e);
        e    = '0;
        e.ix = ix;
        e.iy = iy;
        e.iz = iz;
        e.id = id;
        emit = 1'b0;
        if (m_drain) begin
            if (last) m_drain = 1'b0;
        end else begin
            emit   = 1'b1;
            e.axis = {iz > 6'd31, iy > 6'd31, ix > 6'd31};
            e.oob  = |e.axis;
            if (e.oob) begin
                e.steps    = m_cnt;
                e.end_flag = 1'b1;
                m_cnt      = 8'd0;
                m_drain    = !last;
            end else begin
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                e.steps    = m_cnt;
                e.end_flag = last;
                if (last) m_cnt = 8'd0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance and queue its expected response.
    task automatic applyStimulus(input int sel, input logic [5:0] ix, input logic [5:0] iy,
                                 input logic [5:0] iz, input logic last, input logic [3:0] id,
                                 input logic emit, input logic oob, input logic [2:0] axis,
                                 input logic end_flag, input logic [7:0] steps, input logic use_model);
        beat_t e;
        logic  em;
        int    waited;
        logic  done;
        in_valid[sel]  = 1'b1;
        in_ix[sel]     = ix;
        in_iy[sel]     = iy;
        in_iz[sel]     = iz;
        in_last[sel]   = last;
        in_ray_id[sel] = id;
        waited = 0;
        done   = 1'b0;
        while (!done && waited < 200) begin
            @(negedge clk);
            if (in_ready[sel]) begin
                done = 1'b1;
                if (use_model) begin
                    modelStep(ix, iy, iz, last, id, em, e);
                end else begin
                    em         = emit;
                    e.ix       = ix;
                    e.iy       = iy;
                    e.iz       = iz;
                    e.id       = id;
                    e.oob      = oob;
                    e.axis     = axis;
                    e.end_flag = end_flag;
                    e.steps    = steps;
                end
                if (em) begin
                    if (sel == 0) exp_q0.push_back(e);
                    else          exp_q1.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid[sel] = 1'b0;
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout dut%0d: in_ready stayed 0, expected 1 within 200 cycles", sel);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_ix[s]     = '0;
            in_iy[s]     = '0;
            in_iz[s]     = '0;
            in_last[s]   = 1'b0;
            in_ray_id[s] = '0;
            out_ready[s] = 1'b1;
        end
        m_drain   = 1'b0;
        m_cnt     = 8'd0;
        rand_done = 1'b0;
        rst       = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_ready_during_reset", in_ready[0], 1);
        checkOutput("out_valid_during_reset", out_valid[0], 0);
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid[0], 0);
        checkOutput("reset_out_steps", out_steps[0], 0);
        checkOutput("reset_out_ix", out_ix[0], 0);
        checkOutput("reset_in_ready", in_ready[0], 1);

        // Basic ray with exit on z at the last beat.
        applyStimulus(0, 6'd0, 6'd0, 6'd0, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd1, 1'b0);
        checkOutput("latency_1cycle", out_valid[0], 1);
        applyStimulus(0, 6'd31, 6'd31, 6'd31, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd2, 1'b0);
        applyStimulus(0, 6'd31, 6'd31, 6'd32, 1'b1, 4'd3, 1'b1, 1'b1, 3'b100, 1'b1, 8'd2, 1'b0);
        idle(2);

        // Out-of-bounds mid-ray, remaining steps drained, next ray fresh.
        applyStimulus(0, 6'd10, 6'd10, 6'd10, 1'b0, 4'd5, 1'b1, 1'b0, 3'b000, 1'b0, 8'd1, 1'b0);
        applyStimulus(0, 6'd32, 6'd5, 6'd5, 1'b0, 4'd5, 1'b1, 1'b1, 3'b001, 1'b1, 8'd1, 1'b0);
        applyStimulus(0, 6'd33, 6'd5, 6'd5, 1'b0, 4'd5, 1'b0, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
        applyStimulus(0, 6'd34, 6'd5, 6'd5, 1'b1, 4'd5, 1'b0, 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);
        applyStimulus(0, 6'd1, 6'd1, 6'd1, 1'b1, 4'd6, 1'b1, 1'b0, 3'b000, 1'b1, 8'd1, 1'b0);
        idle(2);

        // Backpressure: output held, input stalled, then no loss on release.
        out_ready[0] = 1'b0;
        applyStimulus(0, 6'd7, 6'd8, 6'd9, 1'b0, 4'd4, 1'b1, 1'b0, 3'b000, 1'b0, 8'd1, 1'b0);
        in_valid[0]  = 1'b1;
        in_ix[0]     = 6'd9;
        in_iy[0]     = 6'd8;
        in_iz[0]     = 6'd7;
        in_last[0]   = 1'b0;
        in_ray_id[0] = 4'd4;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready[0], 0);
            checkOutput("bp_hold_ix", out_ix[0], 7);
            checkOutput("bp_hold_steps", out_steps[0], 1);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        applyStimulus(0, 6'd9, 6'd8, 6'd7, 1'b0, 4'd4, 1'b1, 1'b0, 3'b000, 1'b0, 8'd2, 1'b0);
        applyStimulus(0, 6'd3, 6'd3, 6'd3, 1'b1, 4'd4, 1'b1, 1'b0, 3'b000, 1'b1, 8'd3, 1'b0);
        idle(2);

        // Signed coordinates on the second instance.
        applyStimulus(1, 6'h3F, 6'd0, 6'd0, 1'b1, 4'd1, 1'b1, 1'b1, 3'b001, 1'b1, 8'd0, 1'b0);
        applyStimulus(1, 6'd31, 6'd0, 6'd0, 1'b1, 4'd1, 1'b1, 1'b0, 3'b000, 1'b1, 8'd1, 1'b0);
        applyStimulus(1, 6'd0, 6'd32, 6'd0, 1'b1, 4'd2, 1'b1, 1'b1, 3'b010, 1'b1, 8'd0, 1'b0);

        // Two-bit step counter saturates at 3, next ray restarts at 1.
        applyStimulus(1, 6'd1, 6'd1, 6'd1, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd1, 1'b0);
        applyStimulus(1, 6'd1, 6'd1, 6'd1, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd2, 1'b0);
        applyStimulus(1, 6'd1, 6'd1, 6'd1, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd3, 1'b0);
        applyStimulus(1, 6'd1, 6'd1, 6'd1, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd3, 1'b0);
        applyStimulus(1, 6'd1, 6'd1, 6'd1, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 8'd3, 1'b0);
        applyStimulus(1, 6'd1, 6'd1, 6'd1, 1'b1, 4'd3, 1'b1, 1'b0, 3'b000, 1'b1, 8'd3, 1'b0);
        applyStimulus(1, 6'd2, 6'd2, 6'd2, 1'b1, 4'd4, 1'b1, 1'b0, 3'b000, 1'b1, 8'd1, 1'b0);
        idle(2);

        // Reset while a held beat sits in the output and the FSM is draining.
        applyStimulus(0, 6'd1, 6'd1, 6'd1, 1'b0, 4'd7, 1'b1, 1'b0, 3'b000, 1'b0, 8'd1, 1'b0);
        idle(2);
        out_ready[0] = 1'b0;
        applyStimulus(0, 6'd40, 6'd0, 6'd0, 1'b0, 4'd7, 1'b1, 1'b1, 3'b001, 1'b1, 8'd1, 1'b0);
        checkOutput("drain_out_valid_held", out_valid[0], 1);
        checkOutput("drain_in_ready", in_ready[0], 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_out_valid", out_valid[0], 0);
        checkOutput("async_reset_in_ready", in_ready[0], 1);
        exp_q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready[0] = 1'b1;
        applyStimulus(0, 6'd5, 6'd5, 6'd5, 1'b1, 4'd8, 1'b1, 1'b0, 3'b000, 1'b1, 8'd1, 1'b0);
        idle(3);

        // Randomized traffic against the reference model.
        m_drain = 1'b0;
        m_cnt   = 8'd0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 7) == 0) idle(1);
                    applyStimulus(0, 6'($urandom_range(0, 34)), 6'($urandom_range(0, 34)),
                                  6'($urandom_range(0, 34)), ($urandom_range(0, 4) == 0),
                                  4'(i), 1'b0, 1'b0, 3'b000, 1'b0, 8'd0, 1'b1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready[0] = 1'b1;
        idle(5);

        checkOutput("queue0_drained", exp_q0.size(), 0);
        checkOutput("queue1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
